// File: rtl/pipeline_trace_unit.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_trace_unit
//  Description : Per-instruction trace recorder for an in-order pipeline.
//                It mirrors a valid bit and a record tag for each tracked
//                stage. When a record enters a stage, it stamps the entry
//                cycle into the record. When the record leaves write-back,
//                the unit reports the record's tag, stamps and stall count
//                on a registered retire bus.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk, rst       clock, synchronous active-high reset
//    fetch_valid    new instruction presented to stage 0
//    stall[i]       stage i holds its contents this cycle
//    flush[i]       stage i contents squashed this cycle
//    retire_*       one-cycle retire pulse plus record payload; the payload
//                   holds its value between pulses
//    cycle          free-running cycle counter
//    occupancy      number of records currently allocated
//    overflow       sticky: a fetch was dropped because the table was full
//
//  Configuration macro
//    TRACE_STALL_CNT_EN  adds per-record stall counters (saturating).
//                        Without it, retire_stalls is tied to 0.
// ============================================================================
module pipeline_trace_unit #(
  parameter int NUM_STAGES = 5,
  parameter int DEPTH      = 16,
  parameter int CYC_W      = 32,
  parameter int STALL_W    = 8,
  localparam int TAG_W     = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        fetch_valid,
  input  logic [NUM_STAGES-1:0]       stall,
  input  logic [NUM_STAGES-1:0]       flush,
  output logic                        retire_valid,
  output logic [TAG_W-1:0]            retire_tag,
  output logic [NUM_STAGES*CYC_W-1:0] retire_stamps,
  output logic [STALL_W-1:0]          retire_stalls,
  output logic [CYC_W-1:0]            cycle,
  output logic [TAG_W:0]              occupancy,
  output logic                        overflow
);

  localparam int             LAST     = NUM_STAGES - 1;
  localparam logic [TAG_W:0] FULL_CNT = DEPTH[TAG_W:0];

  // Stage tracking state
  logic [NUM_STAGES-1:0]             stg_valid;
  logic [NUM_STAGES-1:0][TAG_W-1:0]  stg_tag;
  logic [NUM_STAGES-1:0]             stg_valid_nxt;
  logic [NUM_STAGES-1:0][TAG_W-1:0]  stg_tag_nxt;
  logic [NUM_STAGES-1:0]             enter;       // a valid record lands in stage i

  logic [TAG_W-1:0]                  alloc_ptr;
  logic                              full;
  logic                              accept;
  logic                              retire_now;
  logic [TAG_W:0]                    flush_cnt;
  logic [TAG_W:0]                    occ_nxt;

  // Record table: one packed stamp word per record, stage i at [i*CYC_W +: CYC_W]
  logic [NUM_STAGES*CYC_W-1:0]       stamp_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Next-state for the stage shadow pipeline
  // --------------------------------------------------------------------------
  always_comb begin
    full       = (occupancy == FULL_CNT);
    // A fetch squashed by flush[0] in the same cycle is never allocated, so
    // it neither consumes a tag nor counts toward occupancy.
    accept     = fetch_valid & ~stall[0] & ~flush[0] & ~full;
    retire_now = stg_valid[LAST] & ~stall[LAST] & ~flush[LAST];

    stg_valid_nxt = stg_valid;
    stg_tag_nxt   = stg_tag;
    enter         = '0;
    flush_cnt     = '0;

    // Stage 0 takes a freshly allocated tag or becomes empty.
    if (flush[0]) begin
      stg_valid_nxt[0] = 1'b0;
    end else if (!stall[0]) begin
      stg_valid_nxt[0] = accept;
      stg_tag_nxt[0]   = alloc_ptr;
      enter[0]         = accept;
    end

    // Downstream stages take their predecessor. A stalled or flushed
    // predecessor hands over a bubble. A record that sits in stage i while
    // stage i+1 is stalled is overwritten and stays allocated.
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (flush[i]) begin
        stg_valid_nxt[i] = 1'b0;
      end else if (!stall[i]) begin
        stg_valid_nxt[i] = stg_valid[i-1] & ~stall[i-1] & ~flush[i-1];
        stg_tag_nxt[i]   = stg_tag[i-1];
        enter[i]         = stg_valid_nxt[i];
      end
    end

    for (int i = 0; i < NUM_STAGES; i++) begin
      flush_cnt = flush_cnt + {{TAG_W{1'b0}}, (stg_valid[i] & flush[i])};
    end

    occ_nxt = occupancy
            + {{TAG_W{1'b0}}, accept}
            - {{TAG_W{1'b0}}, retire_now}
            - flush_cnt;
  end

  // --------------------------------------------------------------------------
  // Control registers and retire bus
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid     <= '0;
      stg_tag       <= '0;
      alloc_ptr     <= '0;
      occupancy     <= '0;
      cycle         <= '0;
      overflow      <= 1'b0;
      retire_valid  <= 1'b0;
      retire_tag    <= '0;
      retire_stamps <= '0;
    end else begin
      stg_valid    <= stg_valid_nxt;
      stg_tag      <= stg_tag_nxt;
      occupancy    <= occ_nxt;
      cycle        <= cycle + 1'b1;
      retire_valid <= retire_now;
      if (accept) begin
        alloc_ptr <= alloc_ptr + 1'b1;
      end
      if (fetch_valid && !stall[0] && full) begin
        overflow <= 1'b1;
      end
      if (retire_now) begin
        retire_tag    <= stg_tag[LAST];
        retire_stamps <= stamp_mem[stg_tag[LAST]];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stamp table. Allocation wipes the whole record first. The per-stage entry
  // writes follow, so an entry stamp wins over the wipe for the same field.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        stamp_mem[alloc_ptr] <= '0;
      end
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (enter[s]) begin
          stamp_mem[stg_tag_nxt[s]][s*CYC_W +: CYC_W] <= cycle;
        end
      end
    end
  end

`ifdef TRACE_STALL_CNT_EN
  // --------------------------------------------------------------------------
  // Per-record saturating stall counters
  // --------------------------------------------------------------------------
  logic [STALL_W-1:0] stall_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept) begin
        stall_mem[alloc_ptr] <= '0;
      end
      for (int s = 0; s < NUM_STAGES; s++) begin
        if (stg_valid[s] && stall[s] && (stall_mem[stg_tag[s]] != {STALL_W{1'b1}})) begin
          stall_mem[stg_tag[s]] <= stall_mem[stg_tag[s]] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      retire_stalls <= '0;
    end else if (retire_now) begin
      retire_stalls <= stall_mem[stg_tag[LAST]];
    end
  end
`else
  assign retire_stalls = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_trace_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_trace_unit
//  Description : Self-checking bench for pipeline_trace_unit. It checks
//                directed tables and sequences against hand-derived values,
//                then checks random traffic against a reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_trace_unit;

  localparam int NS    = 5;
  localparam int DEPTH = 16;
  localparam int CW    = 32;
  localparam int SW    = 8;
  localparam int TW    = 4;
  localparam int L     = NS - 1;
  localparam int SMAX  = (1 << SW) - 1;
`ifdef TRACE_STALL_CNT_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fetch_valid;
  logic [NS-1:0]        stall;
  logic [NS-1:0]        flush;
  logic                 retire_valid;
  logic [TW-1:0]        retire_tag;
  logic [NS*CW-1:0]     retire_stamps;
  logic [SW-1:0]        retire_stalls;
  logic [CW-1:0]        cycle;
  logic [TW:0]          occupancy;
  logic                 overflow;

  pipeline_trace_unit #(
    .NUM_STAGES(NS), .DEPTH(DEPTH), .CYC_W(CW), .STALL_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .stall(stall), .flush(flush),
    .retire_valid(retire_valid), .retire_tag(retire_tag), .retire_stamps(retire_stamps),
    .retire_stalls(retire_stalls), .cycle(cycle), .occupancy(occupancy), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model. It tracks which record (or -1 for empty) sits in each
  // stage, plus the stamps per record. Occupancy is the running total of
  // allocations minus frees.
  // --------------------------------------------------------------------------
  int            m_pipe [NS];
  logic [CW-1:0] m_stamp [DEPTH][NS];
  int            m_stl [DEPTH];
  int            m_ptr, m_acc, m_freed, m_rtag, m_rstalls;
  logic [CW-1:0] m_cycle;
  bit            m_over, m_rv;
  logic [NS*CW-1:0] m_rstamps;

  task automatic model_update(input bit r, input bit f, input logic [NS-1:0] st, input logic [NS-1:0] fl);
    int np [NS];
    int cnt_new [DEPTH];
    bit full, acc, ret, hit;
    int nflush;
    if (r) begin
      m_cycle = '0; m_ptr = 0; m_acc = 0; m_freed = 0; m_over = 0;
      m_rv = 0; m_rtag = 0; m_rstamps = '0; m_rstalls = 0;
      for (int s = 0; s < NS; s++) m_pipe[s] = -1;
      return;
    end
    ret  = (m_pipe[L] >= 0) && !st[L] && !fl[L];
    m_rv = ret;
    if (ret) begin
      m_rtag = m_pipe[L];
      for (int s = 0; s < NS; s++) m_rstamps[s*CW +: CW] = m_stamp[m_rtag][s];
      m_rstalls = STALL_ON ? m_stl[m_rtag] : 0;
    end
    nflush = 0;
    for (int s = 0; s < NS; s++) if (m_pipe[s] >= 0 && fl[s]) nflush++;
    full = ((m_acc - m_freed) == DEPTH);
    if (f && !st[0] && full) m_over = 1;
    acc = f && !st[0] && !fl[0] && !full;
    for (int rr = 0; rr < DEPTH; rr++) begin
      cnt_new[rr] = m_stl[rr];
      if (acc && rr == m_ptr) cnt_new[rr] = 0;
      hit = 0;
      for (int s = 0; s < NS; s++) if (m_pipe[s] == rr && st[s]) hit = 1;
      if (hit) cnt_new[rr] = (m_stl[rr] + 1 > SMAX) ? SMAX : m_stl[rr] + 1;
    end
    for (int rr = 0; rr < DEPTH; rr++) m_stl[rr] = cnt_new[rr];
    np[0] = fl[0] ? -1 : (st[0] ? m_pipe[0] : (acc ? m_ptr : -1));
    for (int s = 1; s < NS; s++) begin
      if (fl[s])      np[s] = -1;
      else if (st[s]) np[s] = m_pipe[s];
      else            np[s] = (m_pipe[s-1] >= 0 && !st[s-1] && !fl[s-1]) ? m_pipe[s-1] : -1;
    end
    if (acc) for (int s = 0; s < NS; s++) m_stamp[m_ptr][s] = (s == 0) ? m_cycle : '0;
    for (int s = 1; s < NS; s++)
      if (np[s] >= 0 && !fl[s] && !st[s]) m_stamp[np[s]][s] = m_cycle;
    if (acc) m_ptr = (m_ptr + 1) % DEPTH;
    m_acc   += acc ? 1 : 0;
    m_freed += nflush + (ret ? 1 : 0);
    for (int s = 0; s < NS; s++) m_pipe[s] = np[s];
    m_cycle = m_cycle + 1;
  endtask

  task automatic compare_model();
    check("rnd_cycle", cycle, m_cycle);
    check("rnd_occ", occupancy, m_acc - m_freed);
    check("rnd_ovf", overflow, m_over);
    check("rnd_rv", retire_valid, m_rv);
    check("rnd_rtag", retire_tag, m_rtag);
    check("rnd_stamps", retire_stamps, m_rstamps);
    check("rnd_stalls", retire_stalls, m_rstalls);
  endtask

  // One clock: drive inputs, let the edge happen, advance the model, settle.
  task automatic step(input bit r, input bit f, input logic [NS-1:0] st, input logic [NS-1:0] fl);
    rst = r; fetch_valid = f; stall = st; flush = fl;
    @(posedge clk);
    model_update(r, f, st, fl);
    #1;
  endtask

  typedef struct {
    bit            f;
    logic [NS-1:0] st;
    logic [NS-1:0] fl;
    bit            rv;
    int            tag;
    int            occ;
    int            cyc;
  } vec_t;

  vec_t tbl [7];
  int   tags_q [$];
  int   nret, last_tag;

  initial begin
    rst = 1'b1; fetch_valid = 1'b0; stall = '0; flush = '0;

    // Single instruction, no stalls: stamps 1..5, retire visible at cycle 7
    tbl[0] = '{1'b1, 5'b0, 5'b0, 1'b0, 0, 1, 2};
    tbl[1] = '{1'b0, 5'b0, 5'b0, 1'b0, 0, 1, 3};
    tbl[2] = '{1'b0, 5'b0, 5'b0, 1'b0, 0, 1, 4};
    tbl[3] = '{1'b0, 5'b0, 5'b0, 1'b0, 0, 1, 5};
    tbl[4] = '{1'b0, 5'b0, 5'b0, 1'b0, 0, 1, 6};
    tbl[5] = '{1'b0, 5'b0, 5'b0, 1'b1, 0, 0, 7};
    tbl[6] = '{1'b0, 5'b0, 5'b0, 1'b0, 0, 0, 8};

    step(1, 0, '0, '0);
    step(1, 0, '0, '0);
    check("reset_cycle", cycle, 0);
    check("reset_occ", occupancy, 0);
    check("reset_rv", retire_valid, 0);
    check("reset_ovf", overflow, 0);
    check("reset_tag", retire_tag, 0);
    check("reset_stamps", retire_stamps, 0);
    check("reset_stalls", retire_stalls, 0);

    step(0, 0, '0, '0);
    for (int i = 0; i < 7; i++) begin
      step(0, tbl[i].f, tbl[i].st, tbl[i].fl);
      check($sformatf("tbl%0d_rv", i), retire_valid, tbl[i].rv);
      check($sformatf("tbl%0d_occ", i), occupancy, tbl[i].occ);
      check($sformatf("tbl%0d_cyc", i), cycle, tbl[i].cyc);
      if (tbl[i].rv) begin
        check($sformatf("tbl%0d_tag", i), retire_tag, tbl[i].tag);
        check($sformatf("tbl%0d_stamps", i), retire_stamps, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
      end
    end
    check("hold_stamps", retire_stamps, {32'd5, 32'd4, 32'd3, 32'd2, 32'd1});

    // Stage 0 stalled for 3 cycles after entry
    step(1, 0, '0, '0);
    step(0, 0, '0, '0);
    step(0, 1, '0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 5'b00001, '0);
    for (int k = 0; k < 20 && !retire_valid; k++) step(0, 0, '0, '0);
    check("stall_rv", retire_valid, 1);
    check("stall_cycle", cycle, 10);
    check("stall_stamps", retire_stamps, {32'd8, 32'd7, 32'd6, 32'd5, 32'd1});
    check("stall_cnt", retire_stalls, STALL_ON ? 3 : 0);

    // Continuous fetch for 20 cycles
    step(1, 0, '0, '0);
    tags_q.delete();
    for (int k = 0; k < 20; k++) begin
      step(0, 1, '0, '0);
      if (retire_valid) tags_q.push_back(int'(retire_tag));
      if (k >= 4) check($sformatf("stream_occ%0d", k), occupancy, 5);
    end
    for (int k = 0; k < 10; k++) begin
      step(0, 0, '0, '0);
      if (retire_valid) tags_q.push_back(int'(retire_tag));
    end
    check("stream_count", tags_q.size(), 20);
    for (int i = 0; i < tags_q.size(); i++) check($sformatf("stream_tag%0d", i), tags_q[i], i % 16);

    // Flush stages 0 and 1
    step(1, 0, '0, '0);
    step(0, 1, '0, '0);
    step(0, 1, '0, '0);
    check("flush_occ_before", occupancy, 2);
    step(0, 0, '0, 5'b00011);
    check("flush_occ_after", occupancy, 0);
    step(0, 1, '0, '0);
    nret = 0; last_tag = -1;
    for (int k = 0; k < 12; k++) begin
      step(0, 0, '0, '0);
      if (retire_valid) begin nret++; last_tag = int'(retire_tag); end
    end
    check("flush_nret", nret, 1);
    check("flush_tag", last_tag, 2);

    // Overflow with write-back stalled
    step(1, 0, '0, '0);
    for (int k = 0; k < 16; k++) step(0, 1, 5'b10000, '0);
    check("ovf_occ_full", occupancy, 16);
    check("ovf_not_yet", overflow, 0);
    step(0, 1, 5'b10000, '0);
    check("ovf_set", overflow, 1);
    check("ovf_occ_held", occupancy, 16);
    for (int k = 0; k < 6; k++) step(0, 0, '0, '0);
    check("ovf_sticky", overflow, 1);
    step(1, 0, '0, '0);
    check("ovf_cleared", overflow, 0);

    // Reset with records in flight
    step(0, 1, '0, '0);
    step(0, 1, '0, '0);
    step(0, 1, '0, '0);
    check("midrst_occ_before", occupancy, 3);
    step(1, 0, '0, '0);
    check("midrst_cycle", cycle, 0);
    check("midrst_occ", occupancy, 0);
    check("midrst_rv", retire_valid, 0);
    check("midrst_tag", retire_tag, 0);
    check("midrst_stamps", retire_stamps, 0);
    nret = 0;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, '0, '0);
      if (retire_valid) nret++;
    end
    check("midrst_no_retire", nret, 0);

    // Random traffic against the model
    step(1, 0, '0, '0);
    for (int k = 0; k < 600; k++) begin
      logic [NS-1:0] st, fl;
      bit r, f;
      r = ($urandom_range(99) == 0);
      f = ($urandom_range(3) != 0);
      for (int s = 0; s < NS; s++) begin
        st[s] = ($urandom_range(5) == 0);
        fl[s] = ($urandom_range(19) == 0);
      end
      step(r, f, st, fl);
      compare_model();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
